// File: rtl/srl_tap_delay.sv
// Parametrised clock-enabled shift-register delay line.
// WIDTH bits x DEPTH stages with a runtime tap select, a saturating fill counter,
// and a valid flag for the selected tap. The data storage has no reset and no
// init value, so synthesis can map it onto SRL primitives. Only the fill counter
// is reset.
module srl_tap_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    tap,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_last,
  output logic [AW:0]      fill,
  output logic             full
);

  localparam logic [AW:0] DepthV  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] FillOne = (AW + 1)'(1);

  // Storage: no reset, no init, so that it stays SRL-mappable.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] fill_q;
  logic        tap_in_range;

  // Shift one stage per enabled edge; rst is deliberately ignored here.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Count enabled shifts since reset, saturating at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else if (ce && (fill_q < DepthV)) begin
      fill_q <= fill_q + FillOne;
    end
  end

  // Taps at or above DEPTH only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign tap_in_range = 1'b1;
  end else begin : g_npow2
    assign tap_in_range = ({1'b0, tap} < DepthV);
  end

  // Combinational tap read; out-of-range taps fall back to the last stage.
  always_comb begin
    q = mem[DEPTH-1];
    if (tap_in_range) begin
      q = mem[tap];
    end
  end

  assign q_last  = mem[DEPTH-1];
  assign fill    = fill_q;
  // Derived only from the fill register, so there is no combinational path from ce.
  assign full    = (fill_q == DepthV);
  assign q_valid = tap_in_range && (fill_q > {1'b0, tap});

endmodule

// File: tb/tb_srl_tap_delay.sv
// Scoreboard bench for srl_tap_delay. Two instances are used, DEPTH=16 and
// DEPTH=12 (non power of two). Both instances get the same stimulus.
// The reference model keeps the full history of shifted samples in a queue,
// newest first, together with a count of enabled shifts since reset.
module tb_srl_tap_delay;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [7:0] d;
  logic [3:0] tap;

  logic [7:0] q16, ql16, q12, ql12;
  logic       qv16, full16, qv12, full12;
  logic [4:0] fill16, fill12;

  always #5 clk = ~clk;

  srl_tap_delay #(.WIDTH(8), .DEPTH(16)) u_d16 (
    .clk(clk), .rst(rst), .ce(ce), .d(d), .tap(tap),
    .q(q16), .q_valid(qv16), .q_last(ql16), .fill(fill16), .full(full16)
  );

  srl_tap_delay #(.WIDTH(8), .DEPTH(12)) u_d12 (
    .clk(clk), .rst(rst), .ce(ce), .d(d), .tap(tap),
    .q(q12), .q_valid(qv12), .q_last(ql12), .fill(fill12), .full(full12)
  );

  typedef struct {
    logic [7:0] q;
    bit         qk;
    bit         qv;
    int         fill;
    bit         full;
    logic [7:0] ql;
    bit         qlk;
  } exp_t;

  exp_t       sb16[$];
  exp_t       sb12[$];
  logic [7:0] hist[$];
  int         nfill    = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         chk_en   = 0;

  // Expected outputs for the current history, the fill count and the tap.
  function automatic exp_t model(int dep, logic [3:0] t);
    exp_t e;
    int ti  = int'(t);
    int idx = (ti < dep) ? ti : dep - 1;
    int f   = (nfill < dep) ? nfill : dep;
    e.qk   = idx < hist.size();
    e.q    = e.qk ? hist[idx] : 8'h00;
    e.qv   = (ti < dep) && (f > ti);
    e.fill = f;
    e.full = (f == dep);
    e.qlk  = (dep - 1) < hist.size();
    e.ql   = e.qlk ? hist[dep-1] : 8'h00;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tg, input exp_t e, input logic [7:0] aq, input logic aqv,
                     input logic [7:0] aql, input logic [4:0] afill, input logic afull);
    chk({tg, ".q_valid"}, 32'(aqv), 32'(e.qv));
    chk({tg, ".fill"}, 32'(afill), 32'(e.fill));
    chk({tg, ".full"}, 32'(afull), 32'(e.full));
    if (e.qk)  chk({tg, ".q"}, 32'(aq), 32'(e.q));
    if (e.qlk) chk({tg, ".q_last"}, 32'(aql), 32'(e.ql));
  endtask

  // Monitor: the outputs are combinational, so one expectation is popped per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb16.size() > 0) begin
      e = sb16.pop_front();
      cmp("d16", e, q16, qv16, ql16, fill16, full16);
    end
    if (sb12.size() > 0) begin
      e = sb12.pop_front();
      cmp("d12", e, q12, qv12, ql12, fill12, full12);
    end
  end

  // Drive one cycle. Expectations use the pre-edge state and the new tap.
  // The model is then advanced by the edge that samples these inputs.
  task automatic cycle(input logic r, input logic c, input logic [7:0] dv, input logic [3:0] tv);
    rst = r;
    ce  = c;
    d   = dv;
    tap = tv;
    if (chk_en) begin
      sb16.push_back(model(16, tv));
      sb12.push_back(model(12, tv));
    end
    @(posedge clk);
    if (c) begin
      hist.push_front(dv);
      if (hist.size() > 64) void'(hist.pop_back());
    end
    if (r) nfill = 0;
    else if (c) nfill++;
    if (r) chk_en = 1;
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; d = '0; tap = '0;
    cycle(1, 0, 8'h00, 4'd0);
    cycle(1, 0, 8'h00, 4'd0);

    // Incrementing data at tap 3; fill saturates.
    for (int i = 1; i <= 20; i++) cycle(0, 1, 8'(i), 4'd3);

    // Gated enable at tap 1.
    cycle(1, 0, 8'h00, 4'd1);
    cycle(0, 1, 8'hA5, 4'd1);
    cycle(0, 0, 8'h3C, 4'd1);
    cycle(0, 0, 8'h5A, 4'd1);
    cycle(0, 1, 8'h77, 4'd1);
    cycle(0, 0, 8'h11, 4'd1);

    // Fill with d=i, then sweep the tap with the enable low.
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 4'd0);
    for (int t = 0; t < 16; t++) cycle(0, 0, 8'hFF, 4'(t));

    // Mid-run reset with ce high, then hold, then refill.
    cycle(1, 1, 8'hC3, 4'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h99, 4'd0);
    cycle(0, 1, 8'h42, 4'd0);
    cycle(0, 0, 8'h00, 4'd0);
    cycle(0, 0, 8'h00, 4'd13);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 4'($urandom));
    end

    cycle(0, 0, 8'h00, 4'd0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb16.size() + sb12.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
